// File: rtl/pcie_init_seq_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pcie_init_seq_pkg
// Purpose  : Shared types and constants for the PCIe TL-domain bring-up
//            sequencer: the state encoding, the cycle-counter width helper
//            and default timing constants.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package pcie_init_seq_pkg;

    // The numeric encoding is visible on the STATE output, so it is fixed.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_INIT  = 3'd1,
        ST_WAIT_CALIB = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_REL_CORE   = 3'd4,
        ST_WAIT_LINK  = 3'd5,
        ST_RUN        = 3'd6,
        ST_FAULT      = 3'd7
    } state_t;

    localparam int c_SYNC_STAGES_DEF    = 2;
    localparam int c_SETTLE_CYCLES_DEF  = 256;
    localparam int c_STAGGER_CYCLES_DEF = 16;
    localparam int c_TIMEOUT_CYCLES_DEF = 1048576;
    localparam int c_MAX_RETRY_DEF      = 3;

    // One spare bit above what the timeout needs, so the saturating counter
    // can always represent TIMEOUT_CYCLES-1 without hitting its ceiling.
    function automatic int cnt_width(input int timeout_cycles);
        return $clog2(timeout_cycles) + 1;
    endfunction

endpackage : pcie_init_seq_pkg
`default_nettype wire

// File: rtl/pcie_init_sequencer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pcie_init_sequencer_if
// Purpose  : Status / control bundle between the init monitor, the PCIe link
//            and the bring-up sequencer.
//   FABRIC_POR_N, DEVICE_INIT_DONE, BANK0_1_4_CALIB_DONE, BANK_4_VDDI_STATUS,
//   LINK_UP      : asynchronous status into the sequencer
//   CORE_RST_N, FABRIC_RST_N, READY, FAULT, STATE[2:0], RETRY_CNT[3:0]
//                : registered sequencer outputs
//   modport slave  : sequencer side
//   modport master : environment side (drives status, observes outputs)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface pcie_init_sequencer_if;

    logic       FABRIC_POR_N;
    logic       DEVICE_INIT_DONE;
    logic       BANK0_1_4_CALIB_DONE;
    logic       BANK_4_VDDI_STATUS;
    logic       LINK_UP;
    logic       CORE_RST_N;
    logic       FABRIC_RST_N;
    logic       READY;
    logic       FAULT;
    logic [2:0] STATE;
    logic [3:0] RETRY_CNT;

    modport slave (
        input  FABRIC_POR_N, DEVICE_INIT_DONE, BANK0_1_4_CALIB_DONE,
               BANK_4_VDDI_STATUS, LINK_UP,
        output CORE_RST_N, FABRIC_RST_N, READY, FAULT, STATE, RETRY_CNT
    );

    modport master (
        output FABRIC_POR_N, DEVICE_INIT_DONE, BANK0_1_4_CALIB_DONE,
               BANK_4_VDDI_STATUS, LINK_UP,
        input  CORE_RST_N, FABRIC_RST_N, READY, FAULT, STATE, RETRY_CNT
    );

endinterface : pcie_init_sequencer_if
`default_nettype wire

// File: rtl/pcie_init_sequencer_sync_bit_n.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : sync_bit_n
// Purpose  : N-stage single-bit synchronizer with synchronous reset.
//   clk  : destination clock
//   rst  : synchronous active-high reset, clears every stage
//   i_d  : asynchronous input
//   o_q  : synchronized output (last stage)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module sync_bit_n #(
    parameter int N = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic [N-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < N; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[N-1];

endmodule : sync_bit_n
`default_nettype wire

// File: rtl/pcie_init_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pcie_init_sequencer
// Purpose  : Reset / bring-up sequencer for the PCIe transaction-layer domain.
//            Waits for POR, device init, bank calibration and VDDI, settles,
//            releases the PCIe core reset, then the fabric reset, then
//            reports READY once the link is up. Timeouts retry from IDLE;
//            exhausting the retry budget latches a sticky FAULT.
//   TL_CLK : sole clock
//   RESET  : synchronous active-high reset
//   bus    : pcie_init_sequencer_if.slave (status in, resets/status out)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module pcie_init_sequencer
    import pcie_init_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = c_SYNC_STAGES_DEF,
    parameter int SETTLE_CYCLES  = c_SETTLE_CYCLES_DEF,
    parameter int STAGGER_CYCLES = c_STAGGER_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEF,
    parameter int MAX_RETRY      = c_MAX_RETRY_DEF
) (
    input  wire logic              TL_CLK,
    input  wire logic              RESET,
    pcie_init_sequencer_if.slave   bus
);

    localparam int CW = cnt_width(TIMEOUT_CYCLES);

    localparam logic [CW-1:0] c_TMO_LAST     = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] c_SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] c_STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
    localparam logic [3:0]    c_RETRY_LAST   = 4'(MAX_RETRY - 1);

    // ---------------------------------------------------------------- syncs
    // Bit order: 0=por, 1=init, 2=calib, 3=vddi, 4=link
    logic [4:0] w_async;
    logic [4:0] w_sync;

    assign w_async = {bus.LINK_UP, bus.BANK_4_VDDI_STATUS,
                      bus.BANK0_1_4_CALIB_DONE, bus.DEVICE_INIT_DONE,
                      bus.FABRIC_POR_N};

    for (genvar g = 0; g < 5; g++) begin : g_sync
        sync_bit_n #(.N(SYNC_STAGES)) u_sync (
            .clk (TL_CLK),
            .rst (RESET),
            .i_d (w_async[g]),
            .o_q (w_sync[g])
        );
    end

    logic w_por_s, w_init_s, w_calib_s, w_vddi_s, w_link_s;
    assign w_por_s   = w_sync[0];
    assign w_init_s  = w_sync[1];
    assign w_calib_s = w_sync[2];
    assign w_vddi_s  = w_sync[3];
    assign w_link_s  = w_sync[4];

    // ---------------------------------------------------------------- state
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_retry;
    logic            r_core_rst_n;
    logic            r_fabric_rst_n;
    logic            r_ready;
    logic            r_fault;

    state_t w_nxt;
    logic   w_supply_loss;
    logic   w_timeout;
    logic   w_retry_inc;
    logic   w_bank_ok;

    assign w_bank_ok = w_calib_s & w_vddi_s;

    // Losing POR always restarts; losing bank power only matters once the
    // core reset has been released (SETTLE handles it by re-waiting).
    assign w_supply_loss = !w_por_s ||
        (!w_bank_ok && (r_state inside {ST_REL_CORE, ST_WAIT_LINK, ST_RUN}));

    assign w_timeout = (r_cnt == c_TMO_LAST) &&
        (r_state inside {ST_WAIT_INIT, ST_WAIT_CALIB, ST_WAIT_LINK});

    always_comb begin
        w_nxt       = r_state;
        w_retry_inc = 1'b0;
        if (r_state == ST_FAULT) begin
            w_nxt = ST_FAULT;
        end else if (w_supply_loss) begin
            w_nxt = ST_IDLE;
        end else if (w_timeout) begin
            if (r_retry == c_RETRY_LAST) begin
                w_nxt = ST_FAULT;
            end else begin
                w_nxt       = ST_IDLE;
                w_retry_inc = 1'b1;
            end
        end else begin
            unique case (r_state)
                ST_IDLE:       w_nxt = ST_WAIT_INIT;   // por_s known high here
                ST_WAIT_INIT:  if (w_init_s)  w_nxt = ST_WAIT_CALIB;
                ST_WAIT_CALIB: if (w_bank_ok) w_nxt = ST_SETTLE;
                ST_SETTLE: begin
                    if (!w_bank_ok)                   w_nxt = ST_WAIT_CALIB;
                    else if (r_cnt == c_SETTLE_LAST)  w_nxt = ST_REL_CORE;
                end
                ST_REL_CORE:   if (r_cnt == c_STAGGER_LAST) w_nxt = ST_WAIT_LINK;
                ST_WAIT_LINK:  if (w_link_s)  w_nxt = ST_RUN;
                ST_RUN:        if (!w_link_s) w_nxt = ST_WAIT_LINK;
                default:       w_nxt = ST_FAULT;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as STATE.
    always_ff @(posedge TL_CLK) begin
        if (RESET) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_retry        <= '0;
            r_core_rst_n   <= 1'b0;
            r_fabric_rst_n <= 1'b0;
            r_ready        <= 1'b0;
            r_fault        <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_retry_inc) begin
                r_retry <= r_retry + 1'b1;
            end
            r_core_rst_n   <= (w_nxt inside {ST_REL_CORE, ST_WAIT_LINK, ST_RUN});
            r_fabric_rst_n <= (w_nxt inside {ST_WAIT_LINK, ST_RUN});
            r_ready        <= (w_nxt == ST_RUN);
            r_fault        <= (w_nxt == ST_FAULT);
        end
    end

    assign bus.STATE        = r_state;
    assign bus.RETRY_CNT    = r_retry;
    assign bus.CORE_RST_N   = r_core_rst_n;
    assign bus.FABRIC_RST_N = r_fabric_rst_n;
    assign bus.READY        = r_ready;
    assign bus.FAULT        = r_fault;

endmodule : pcie_init_sequencer
`default_nettype wire
